// File: rtl/phy_pkg.sv
// phy_pkg: state encoding and 200 MHz DDR3 timing defaults for the PHY reset sequencer
package phy_pkg;
    typedef enum logic [2:0] {
        S_PLL_RST,
        S_WAIT_LOCK,
        S_LOCK_STABLE,
        S_IDLY_RST,
        S_IDLY_WAIT,
        S_DDR_RST,
        S_CKE_WAIT,
        S_DONE
    } phy_init_state_t;
    localparam int PLL_RST_CYC_DEF     = 16;
    localparam int LOCK_TIMEOUT_DEF    = 4096;
    localparam int LOCK_STABLE_CYC_DEF = 256;
    localparam int IDLY_RST_CYC_DEF    = 16;
    localparam int IDLY_TIMEOUT_DEF    = 1024;
    localparam int DDR_RST_CYC_DEF     = 40000;
    localparam int CKE_WAIT_CYC_DEF    = 100000;
    localparam int CNT_W_DEF           = 20;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous level
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/phy_reset_seq.sv
// phy_reset_seq: PLL lock, IDELAYCTRL/SERDES release and DDR3 RESET#/CKE power-up sequencer
module phy_reset_seq
    import phy_pkg::*;
#(
    parameter int PLL_RST_CYC     = PLL_RST_CYC_DEF,
    parameter int LOCK_TIMEOUT    = LOCK_TIMEOUT_DEF,
    parameter int LOCK_STABLE_CYC = LOCK_STABLE_CYC_DEF,
    parameter int IDLY_RST_CYC    = IDLY_RST_CYC_DEF,
    parameter int IDLY_TIMEOUT    = IDLY_TIMEOUT_DEF,
    parameter int DDR_RST_CYC     = DDR_RST_CYC_DEF,
    parameter int CKE_WAIT_CYC    = CKE_WAIT_CYC_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic       clkin,
    input  logic       reset_n,
    input  logic       pll_locked,
    input  logic       idelay_rdy,
    output logic       pll_reset,
    output logic       idelayctrl_rst,
    output logic       serdes_rst,
    output logic       ddr_reset_n,
    output logic       ddr_cke,
    output logic       phy_ready,
    output logic [7:0] retry_cnt,
    output logic [2:0] init_state
);
    localparam logic [CNT_W-1:0] PLL_LAST    = CNT_W'(PLL_RST_CYC - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] IRST_LAST   = CNT_W'(IDLY_RST_CYC - 1);
    localparam logic [CNT_W-1:0] ITO_LAST    = CNT_W'(IDLY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] DDR_LAST    = CNT_W'(DDR_RST_CYC - 1);
    localparam logic [CNT_W-1:0] CKE_LAST    = CNT_W'(CKE_WAIT_CYC - 1);

    phy_init_state_t state, nxt;
    logic [CNT_W-1:0] cnt;
    logic lock_s, rdy_s, bump;

    sync_2ff #(.RST_VAL(1'b0)) u_lock_sync (.clk(clkin), .rst_n(reset_n), .d(pll_locked), .q(lock_s));
    sync_2ff #(.RST_VAL(1'b0)) u_rdy_sync  (.clk(clkin), .rst_n(reset_n), .d(idelay_rdy), .q(rdy_s));

    assign init_state = state;

    // Lock loss once the IDELAYCTRL stage has started outranks every other event
    always_comb begin
        nxt  = state;
        bump = 1'b0;
        if (state >= S_IDLY_RST && !lock_s) begin
            nxt  = S_PLL_RST;
            bump = 1'b1;
        end else begin
            case (state)
                S_PLL_RST:     if (cnt == PLL_LAST) nxt = S_WAIT_LOCK;
                S_WAIT_LOCK:   if (lock_s) nxt = S_LOCK_STABLE;
                               else if (cnt == LOCK_LAST) begin
                                   nxt  = S_PLL_RST;
                                   bump = 1'b1;
                               end
                S_LOCK_STABLE: if (!lock_s) nxt = S_WAIT_LOCK;
                               else if (cnt == STABLE_LAST) nxt = S_IDLY_RST;
                S_IDLY_RST:    if (cnt == IRST_LAST) nxt = S_IDLY_WAIT;
                S_IDLY_WAIT:   if (rdy_s) nxt = S_DDR_RST;
                               else if (cnt == ITO_LAST) begin
                                   nxt  = S_IDLY_RST;
                                   bump = 1'b1;
                               end
                S_DDR_RST:     if (cnt == DDR_LAST) nxt = S_CKE_WAIT;
                S_CKE_WAIT:    if (cnt == CKE_LAST) nxt = S_DONE;
                default:       nxt = state;
            endcase
        end
    end

    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_PLL_RST;
            cnt            <= '0;
            retry_cnt      <= '0;
            pll_reset      <= 1'b1;
            idelayctrl_rst <= 1'b1;
            serdes_rst     <= 1'b1;
            ddr_reset_n    <= 1'b0;
            ddr_cke        <= 1'b0;
            phy_ready      <= 1'b0;
        end else begin
            state          <= nxt;
            cnt            <= (nxt != state) ? '0 : cnt + CNT_W'(1);
            retry_cnt      <= (bump && retry_cnt != 8'hff) ? retry_cnt + 8'd1 : retry_cnt;
            pll_reset      <= nxt == S_PLL_RST;
            idelayctrl_rst <= nxt <= S_IDLY_RST;
            serdes_rst     <= nxt <= S_IDLY_WAIT;
            ddr_reset_n    <= nxt >= S_CKE_WAIT;
            ddr_cke        <= nxt == S_DONE;
            phy_ready      <= nxt == S_DONE;
        end
    end
endmodule

// File: tb/tb_phy_reset_seq.sv
// tb_phy_reset_seq: directed bring-up, retry, glitch, lock-loss and async-reset scenarios
module tb_phy_reset_seq;
    logic       clkin, reset_n, pll_locked, idelay_rdy;
    logic       pll_reset, idelayctrl_rst, serdes_rst, ddr_reset_n, ddr_cke, phy_ready;
    logic [7:0] retry_cnt;
    logic [2:0] init_state;
    int n_checks = 0;
    int n_errors = 0;

    phy_reset_seq #(
        .PLL_RST_CYC(4), .LOCK_TIMEOUT(20), .LOCK_STABLE_CYC(8), .IDLY_RST_CYC(4),
        .IDLY_TIMEOUT(10), .DDR_RST_CYC(50), .CKE_WAIT_CYC(100), .CNT_W(20)
    ) dut (
        .clkin(clkin), .reset_n(reset_n), .pll_locked(pll_locked), .idelay_rdy(idelay_rdy),
        .pll_reset(pll_reset), .idelayctrl_rst(idelayctrl_rst), .serdes_rst(serdes_rst),
        .ddr_reset_n(ddr_reset_n), .ddr_cke(ddr_cke), .phy_ready(phy_ready),
        .retry_cnt(retry_cnt), .init_state(init_state)
    );

    initial clkin = 1'b0;
    always #5 clkin = ~clkin;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clkin);
    endtask

    // Counts consecutive samples spent in st, waiting (bounded) for it to start
    task automatic measure(input logic [2:0] st, output int n);
        int guard = 0;
        n = 0;
        while (init_state != st && guard < 1000) begin
            @(negedge clkin);
            guard++;
        end
        while (init_state == st && n < 1000) begin
            @(negedge clkin);
            n++;
        end
    endtask

    task automatic pll_width(input logic lvl, output int n);
        n = 0;
        while (pll_reset == lvl && n < 5000) begin
            @(negedge clkin);
            n++;
        end
    endtask

    task automatic wait_state(input string tag, input logic [2:0] st);
        int guard = 0;
        while (init_state != st && guard < 2000) begin
            @(negedge clkin);
            guard++;
        end
        check(tag, init_state, st);
    endtask

    task automatic check_reset_outputs(input string tag, input int retries);
        check({tag, "_pll_reset"}, pll_reset, 1);
        check({tag, "_idly_rst"}, idelayctrl_rst, 1);
        check({tag, "_serdes_rst"}, serdes_rst, 1);
        check({tag, "_ddr_reset_n"}, ddr_reset_n, 0);
        check({tag, "_cke"}, ddr_cke, 0);
        check({tag, "_ready"}, phy_ready, 0);
        check({tag, "_state"}, init_state, 0);
        check({tag, "_retry"}, retry_cnt, retries);
    endtask

    initial begin
        int n;
        reset_n = 1'b0;
        pll_locked = 1'b0;
        idelay_rdy = 1'b0;
        tick(3);
        check_reset_outputs("por", 0);
        // Clean bring-up
        reset_n = 1'b1;
        pll_width(1'b1, n);
        check("s1_pll_high", n, 4);
        tick(6);
        pll_locked = 1'b1;
        measure(3'd2, n);
        check("s1_stable_len", n, 8);
        measure(3'd3, n);
        check("s1_idly_rst_len", n, 4);
        check("s1_idly_rst_low", idelayctrl_rst, 0);
        check("s1_serdes_held", serdes_rst, 1);
        tick(3);
        idelay_rdy = 1'b1;
        measure(3'd4, n);
        check("s1_idly_wait_len", n, 3);
        check("s1_serdes_rel", serdes_rst, 0);
        check("s1_ddr_rst_low", ddr_reset_n, 0);
        measure(3'd5, n);
        check("s1_ddr_rst_len", n, 50);
        check("s1_ddr_rst_high", ddr_reset_n, 1);
        check("s1_cke_low", ddr_cke, 0);
        measure(3'd6, n);
        check("s1_cke_wait_len", n, 100);
        check("s1_cke", ddr_cke, 1);
        check("s1_ready", phy_ready, 1);
        check("s1_retry", retry_cnt, 0);
        // Lock loss in S_DONE
        pll_locked = 1'b0;
        tick(2);
        check("s5_ready_hold", phy_ready, 1);
        tick(1);
        check_reset_outputs("s5_loss", 1);
        pll_locked = 1'b1;
        pll_width(1'b1, n);
        check("s5_pll_high", n, 4);
        wait_state("s5_rerun", 3'd6);
        tick(5);
        check("s5_retry_kept", retry_cnt, 1);
        // Async reset between edges in S_CKE_WAIT
        #1 reset_n = 1'b0;
        #1 check_reset_outputs("s6_async", 0);
        pll_locked = 1'b0;
        idelay_rdy = 1'b0;
        tick(2);
        // Lock glitch during S_LOCK_STABLE
        reset_n = 1'b1;
        wait_state("s3_wait_lock", 3'd1);
        pll_locked = 1'b1;
        wait_state("s3_stable", 3'd2);
        tick(4);
        pll_locked = 1'b0;
        tick(3);
        check("s3_back_wait", init_state, 1);
        check("s3_retry", retry_cnt, 0);
        pll_locked = 1'b1;
        measure(3'd1, n);
        check("s3_wait_len", n, 3);
        measure(3'd2, n);
        check("s3_fresh_stable", n, 8);
        // IDELAY timeout
        measure(3'd3, n);
        check("s4_idly_rst_len", n, 4);
        measure(3'd4, n);
        check("s4_timeout_len", n, 10);
        check("s4_retry1", retry_cnt, 1);
        check("s4_repulse", idelayctrl_rst, 1);
        check("s4_serdes", serdes_rst, 1);
        measure(3'd3, n);
        check("s4_idly_rst_len2", n, 4);
        measure(3'd4, n);
        check("s4_timeout_len2", n, 10);
        check("s4_retry2", retry_cnt, 2);
        measure(3'd3, n);
        tick(1);
        idelay_rdy = 1'b1;
        measure(3'd4, n);
        check("s4_rdy_wait_len", n, 3);
        check("s4_ddr_state", init_state, 5);
        check("s4_serdes_rel", serdes_rst, 0);
        check("s4_retry_kept", retry_cnt, 2);
        // Lock never arrives
        reset_n = 1'b0;
        pll_locked = 1'b0;
        idelay_rdy = 1'b0;
        tick(2);
        reset_n = 1'b1;
        pll_width(1'b1, n);
        check("s2_pll_high", n, 4);
        pll_width(1'b0, n);
        check("s2_pll_low", n, 20);
        check("s2_retry1", retry_cnt, 1);
        pll_width(1'b1, n);
        check("s2_pll_high2", n, 4);
        check("s2_retry_hold", retry_cnt, 1);
        n = 0;
        while (retry_cnt != 8'hff && n < 7000) begin
            @(negedge clkin);
            n++;
        end
        check("s2_sat_reach", retry_cnt, 255);
        tick(60);
        check("s2_saturated", retry_cnt, 255);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
